// File: rtl/serial_frame_deserializer_pkg.sv
// Shared types for the serial frame deserializer.
// Holds the receive FSM state encoding and the default data width.
package serial_frame_deserializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: start(1), WIDTH data bits LSB first, stop(0).
// Ports: clk, rst (async high), serial_in, bit_en (sample strobe),
//        data_out/data_valid/data_ready (holding register handshake),
//        frame_err, overflow (one-cycle pulses), busy (not IDLE).
module serial_frame_deserializer
    import serial_frame_deserializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic             busy
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             ferr_n;
    logic             ovf_n;
    logic             free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            data_out   <= data_n;
            data_valid <= valid_n;
            frame_err  <= ferr_n;
            overflow   <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        data_n  = data_out;
        ferr_n  = 1'b0;
        ovf_n   = 1'b0;
        // Holding register can take a word if empty or drained this edge.
        free    = !data_valid || data_ready;
        valid_n = data_valid && !data_ready;

        if (bit_en) begin
            unique case (state)
                IDLE: begin
                    if (serial_in) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    shreg_n = {serial_in, shreg[WIDTH-1:1]};
                    cnt_n   = cnt + ONE;
                    if (cnt == LAST) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    // A 1 here is a framing error, never a new start bit.
                    state_n = IDLE;
                    if (serial_in) begin
                        ferr_n = 1'b1;
                    end else if (free) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/serial_frame_deserializer.md
SERIAL_FRAME_DESERIALIZER -- requirements
Module: serial_frame_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data bits per frame; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port serial_in, input, 1 bit: serial line, driven by siso_shift_register serial_out.
REQ-005 The block SHALL have port bit_en, input, 1 bit: sample strobe; serial_in is sampled only on edges where bit_en=1.
REQ-006 The block SHALL have port data_out, output, WIDTH bits: received word, LSB received first.
REQ-007 The block SHALL have port data_valid, output, 1 bit: data_out holds an unconsumed word.
REQ-008 The block SHALL have port data_ready, input, 1 bit: the consumer accepts data_out on edges where data_valid=1.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 The block SHALL have port overflow, output, 1 bit: one-cycle pulse when a good word is dropped because the holding register is full.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 The block SHALL use the frame format: idle line 0, start bit 1, WIDTH data bits LSB first, stop bit 0.
REQ-013 The FSM SHALL have states IDLE, DATA and STOP; transitions occur only on edges with bit_en=1.
REQ-014 In IDLE, on sampling serial_in=1, the FSM SHALL enter DATA with bit counter = 0; on sampling 0 it SHALL stay in IDLE.
REQ-015 In DATA, each sample SHALL shift serial_in into the MSB of the shift register (right shift) and increment the counter.
REQ-016 The FSM SHALL leave DATA for STOP after the WIDTH-th data sample; the counter SHALL be $clog2(WIDTH)+1 bits and SHALL never wrap.
REQ-017 In STOP, when the sample is 0 (good frame) and the holding register is free (data_valid=0, or data_ready=1 on the same edge), the block SHALL load data_out and assert data_valid on the next cycle.
REQ-018 In STOP, when the sample is 0 and the holding register is not free (data_valid=1, data_ready=0), the block SHALL drop the new word, pulse overflow for one cycle, and leave data_out unchanged.
REQ-019 In STOP, when the sample is 1, the block SHALL pulse frame_err for one cycle, discard the word, and return to IDLE; that 1 SHALL NOT be treated as a new start bit.
REQ-020 Every exit from STOP SHALL return to IDLE.
REQ-021 data_valid SHALL clear on an edge with data_valid=1 and data_ready=1, unless a new word loads on the same edge, in which case data_valid SHALL stay 1 and carry the new data.
REQ-022 data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-023 With bit_en held at 1, and the start bit sampled at edge k, data_valid SHALL be high after edge k+WIDTH+1.
REQ-024 On edges with bit_en=0, state, counter and shift register SHALL hold; the handshake (REQ-021) SHALL still operate.
REQ-025 frame_err and overflow SHALL never be high in the same cycle.

Reset
REQ-026 While rst=1, the block SHALL force: state=IDLE, counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, overflow=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without any valid, error or overflow pulse.
REQ-028 After rst deasserts, the first sampled 1 SHALL be treated as a start bit.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, DATA, STOP) and the default WIDTH constant.
REQ-030 The block SHALL be a single module with no sub-module; the shift register and FSM are inline.

Verification (WIDTH=8 unless stated)
REQ-031 Basic frame: bit_en=1, data_ready=1; drive 1,1,0,1,0,0,1,0,1,0 (start, 0xA5 LSB first, stop) -> data_valid high for one cycle with data_out=0xA5, 9 edges after the start sample; frame_err=0 and overflow=0.
REQ-032 Bad stop: the same frame with stop bit 1 -> frame_err pulses one cycle, data_valid stays 0, FSM in IDLE; the next good frame 0x3C is received correctly.
REQ-033 Overflow: data_ready=0; send 0x11 then 0x22 -> data_out=0x11 is held, overflow pulses once; after data_ready=1, data_valid clears and data_out stays 0x11.
REQ-034 Simultaneous: 0x11 valid; raise data_ready on the exact edge 0x22's stop is sampled -> data_valid stays 1 with data_out=0x22, no overflow.
REQ-035 Reset mid-frame: rst=1 after 4 data bits -> busy=0 and no pulses; the next frame 0x5A is received correctly.
REQ-036 Strobe gating: bit_en high 1 cycle in 4; send 0xC3 -> data_out=0xC3, same as with bit_en held at 1.
